// File: rtl/axi_isolate_err_front_pkg.sv
// Shared AXI definitions for the isolate error front: widths, response and
// atomic codes, request/response channel structs and FSM state encodings.
package axi_isolate_err_front_pkg;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 64;
    localparam int unsigned UserW = 1;

    // Bit of aw.atop that marks an atomic which also returns read data.
    localparam int unsigned ATOP_R_RESP = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [IdW-1:0]     id_t;
    typedef logic [AddrW-1:0]   addr_t;
    typedef logic [DataW-1:0]   data_t;
    typedef logic [DataW/8-1:0] strb_t;
    typedef logic [UserW-1:0]   user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic       {RIdle, RData}        r_state_e;

    // True when an AW atomic opcode expects a read response as well as B.
    function automatic logic atop_has_r_resp(input logic [5:0] atop);
        return atop[ATOP_R_RESP];
    endfunction

endpackage

// File: rtl/axi_isolate_err_front.sv
// Error front for the AXI isolation stage: while downstream is isolated, new
// AW/AR are accepted locally and answered with error B / R beats; otherwise
// every channel passes straight through.
module axi_isolate_err_front
    import axi_isolate_err_front_pkg::*;
#(
    parameter type        axi_req_t  = axi_isolate_err_front_pkg::axi_req_t,
    parameter type        axi_resp_t = axi_isolate_err_front_pkg::axi_resp_t,
    parameter logic [1:0] ErrResp    = RESP_DECERR,
    parameter logic [63:0] ErrData   = 64'h0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    input  logic      isolated_i
);

    typedef logic [$bits(slv_req_i.aw.id)-1:0]    err_id_t;
    typedef logic [$bits(slv_resp_o.r.data)-1:0]  err_data_t;

    w_state_e   w_state_q, w_state_d;
    r_state_e   r_state_q, r_state_d;
    err_id_t    w_id_q, w_id_d;
    err_id_t    r_id_q, r_id_d;
    logic [7:0] r_cnt_q, r_cnt_d;

    // Error routing is only considered out of reset so that reset is a pure
    // pass-through regardless of the isolation flag.
    logic iso_active;
    assign iso_active = isolated_i & rst_ni;

    // Write-side controls
    logic aw_hold, aw_accept, w_absorb, b_err, atop_load;
    // Read-side controls
    logic ar_hold, ar_accept, r_err;

    // Write FSM: accept AW locally, soak up its W beats, then return one error B.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        aw_hold   = 1'b0;
        aw_accept = 1'b0;
        w_absorb  = 1'b0;
        b_err     = 1'b0;
        atop_load = 1'b0;
        case (w_state_q)
            WIdle: begin
                if (iso_active && slv_req_i.aw_valid) begin
                    aw_hold = 1'b1;
                    // An atomic needing an R beat must wait for the read FSM.
                    if (!atop_has_r_resp(slv_req_i.aw.atop) || (r_state_q == RIdle)) begin
                        aw_accept = 1'b1;
                        w_id_d    = slv_req_i.aw.id;
                        w_state_d = WData;
                        atop_load = atop_has_r_resp(slv_req_i.aw.atop);
                    end
                end
            end
            WData: begin
                aw_hold  = 1'b1;
                w_absorb = 1'b1;
                if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = WResp;
            end
            WResp: begin
                // Holding AW here keeps the error B ahead of any later real B.
                aw_hold = 1'b1;
                b_err   = 1'b1;
                if (slv_req_i.b_ready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
        end
    end

    // Read FSM: accept AR locally (or take an atomic's R beat) and stream error beats.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        ar_hold   = 1'b0;
        ar_accept = 1'b0;
        r_err     = 1'b0;
        case (r_state_q)
            RIdle: begin
                if (iso_active && slv_req_i.ar_valid) begin
                    ar_hold = 1'b1;
                    // A same-cycle atomic AW claims the read FSM first.
                    if (!atop_load) begin
                        ar_accept = 1'b1;
                        r_id_d    = slv_req_i.ar.id;
                        r_cnt_d   = slv_req_i.ar.len;
                        r_state_d = RData;
                    end
                end
                if (atop_load) begin
                    r_id_d    = slv_req_i.aw.id;
                    r_cnt_d   = '0;
                    r_state_d = RData;
                end
            end
            RData: begin
                ar_hold = 1'b1;
                r_err   = 1'b1;
                if (slv_req_i.r_ready) begin
                    if (r_cnt_q == '0) r_state_d = RIdle;
                    else               r_cnt_d   = r_cnt_q - 8'd1;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Channel muxing: pass-through by default, overridden by the FSM controls.
    always_comb begin
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;
        if (aw_hold) begin
            mst_req_o.aw_valid  = 1'b0;
            slv_resp_o.aw_ready = aw_accept;
        end
        if (w_absorb) begin
            mst_req_o.w_valid  = 1'b0;
            slv_resp_o.w_ready = 1'b1;
        end
        if (b_err) begin
            slv_resp_o.b_valid = 1'b1;
            slv_resp_o.b.id    = w_id_q;
            slv_resp_o.b.resp  = ErrResp;
            slv_resp_o.b.user  = '0;
            mst_req_o.b_ready  = 1'b0;
        end
        if (ar_hold) begin
            mst_req_o.ar_valid  = 1'b0;
            slv_resp_o.ar_ready = ar_accept;
        end
        if (r_err) begin
            slv_resp_o.r_valid = 1'b1;
            slv_resp_o.r.id    = r_id_q;
            slv_resp_o.r.data  = err_data_t'(ErrData);
            slv_resp_o.r.resp  = ErrResp;
            slv_resp_o.r.last  = (r_cnt_q == '0);
            slv_resp_o.r.user  = '0;
            mst_req_o.r_ready  = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_isolate_err_front.sv
// Directed bench for axi_isolate_err_front: pass-through, error write, error
// read burst, atomic/read interlock, late isolation drop and mid-burst reset.
module tb_axi_isolate_err_front;
    import axi_isolate_err_front_pkg::*;

    logic      clk_i, rst_ni, isolated_i;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    int        checks = 0;
    int        errors = 0;
    int        beats;
    int        rr [5] = '{1, 0, 1, 1, 1};

    axi_isolate_err_front dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .isolated_i (isolated_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_bus();
        slv_req  = '0;
        mst_resp = '0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        isolated_i = 1'b1;
        idle_bus();
        @(negedge clk_i);

        // Reset: pure pass-through even with isolated_i high
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        #1;
        chk("rst_mst_aw_valid", mst_req.aw_valid, 1);
        chk("rst_slv_aw_ready", slv_resp.aw_ready, 1);
        chk("rst_b_valid", slv_resp.b_valid, 0);
        chk("rst_r_valid", slv_resp.r_valid, 0);
        tick();
        idle_bus();
        isolated_i = 1'b0;
        rst_ni     = 1'b1;
        tick();

        // Pass-through write and read
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd3; slv_req.aw.len = 8'd1;
        mst_resp.aw_ready = 1'b1;
        #1;
        chk("pt_aw_valid", mst_req.aw_valid, 1);
        chk("pt_aw_id", mst_req.aw.id, 3);
        chk("pt_aw_ready", slv_resp.aw_ready, 1);
        chk("pt_no_b", slv_resp.b_valid, 0);
        chk("pt_no_r", slv_resp.r_valid, 0);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b1; slv_req.w.data = 64'h11; slv_req.w.last = 1'b0;
        mst_resp.w_ready = 1'b1;
        #1;
        chk("pt_w_valid", mst_req.w_valid, 1);
        chk("pt_w_data", mst_req.w.data, 64'h11);
        chk("pt_w_ready", slv_resp.w_ready, 1);
        tick();
        slv_req.w.data = 64'h22; slv_req.w.last = 1'b1;
        #1;
        chk("pt_w_last", mst_req.w.last, 1);
        tick();
        slv_req.w_valid = 1'b0;
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3; mst_resp.b.resp = RESP_OKAY;
        slv_req.b_ready = 1'b1;
        #1;
        chk("pt_b_valid", slv_resp.b_valid, 1);
        chk("pt_b_id", slv_resp.b.id, 3);
        chk("pt_b_resp", slv_resp.b.resp, 0);
        chk("pt_b_ready", mst_req.b_ready, 1);
        tick();
        mst_resp.b_valid = 1'b0;
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd3; slv_req.ar.len = 8'd3;
        mst_resp.ar_ready = 1'b1;
        #1;
        chk("pt_ar_valid", mst_req.ar_valid, 1);
        chk("pt_ar_len", mst_req.ar.len, 3);
        chk("pt_ar_ready", slv_resp.ar_ready, 1);
        tick();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd3; mst_resp.r.data = 64'hABCD;
        mst_resp.r.last = 1'b1;
        slv_req.r_ready = 1'b1;
        #1;
        chk("pt_r_valid", slv_resp.r_valid, 1);
        chk("pt_r_data", slv_resp.r.data, 64'hABCD);
        chk("pt_r_ready", mst_req.r_ready, 1);
        tick();
        idle_bus();

        // Error write: AW id 5 plus four W beats
        isolated_i = 1'b1;
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd5;
        #1;
        chk("ew_mst_aw_valid", mst_req.aw_valid, 0);
        chk("ew_aw_ready", slv_resp.aw_ready, 1);
        tick();
        slv_req.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slv_req.w_valid = 1'b1;
            slv_req.w.last  = (i == 3);
            #1;
            chk("ew_mst_w_valid", mst_req.w_valid, 0);
            chk("ew_w_ready", slv_resp.w_ready, 1);
            chk("ew_b_early", slv_resp.b_valid, 0);
            tick();
        end
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        #1;
        chk("ew_b_valid", slv_resp.b_valid, 1);
        chk("ew_b_id", slv_resp.b.id, 5);
        chk("ew_b_resp", slv_resp.b.resp, 3);
        chk("ew_mst_b_ready", mst_req.b_ready, 0);
        tick();
        #1;
        chk("ew_b_hold", slv_resp.b_valid, 1);
        slv_req.b_ready = 1'b1;
        tick();
        slv_req.b_ready = 1'b0;
        #1;
        chk("ew_b_done", slv_resp.b_valid, 0);
        tick();

        // Error read: AR id 2 len 3 with r_ready pattern 1,0,1,1,1
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd2; slv_req.ar.len = 8'd3;
        #1;
        chk("er_mst_ar_valid", mst_req.ar_valid, 0);
        chk("er_ar_ready", slv_resp.ar_ready, 1);
        chk("er_r_same_cycle", slv_resp.r_valid, 0);
        tick();
        slv_req.ar_valid = 1'b0;
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            slv_req.r_ready = rr[i][0];
            #1;
            chk("er_r_valid", slv_resp.r_valid, 1);
            chk("er_r_id", slv_resp.r.id, 2);
            chk("er_r_data", slv_resp.r.data, 0);
            chk("er_r_resp", slv_resp.r.resp, 3);
            chk("er_r_last", slv_resp.r.last, (beats == 3));
            chk("er_mst_r_ready", mst_req.r_ready, 0);
            if (rr[i] == 1) beats++;
            tick();
        end
        slv_req.r_ready = 1'b0;
        #1;
        chk("er_r_done", slv_resp.r_valid, 0);
        tick();

        // Atomic AW with R response while a read error burst is active
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd1; slv_req.ar.len = 8'd2;
        tick();
        slv_req.ar_valid = 1'b0;
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd7; slv_req.aw.atop = 6'b100000;
        slv_req.r_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("at_aw_blocked", slv_resp.aw_ready, 0);
            chk("at_mst_aw_valid", mst_req.aw_valid, 0);
            chk("at_burst_r_id", slv_resp.r.id, 1);
            tick();
        end
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd9; slv_req.ar.len = 8'd0;
        #1;
        chk("at_aw_ready", slv_resp.aw_ready, 1);
        chk("at_ar_loses", slv_resp.ar_ready, 0);
        chk("at_mst_ar_valid", mst_req.ar_valid, 0);
        chk("at_r_idle", slv_resp.r_valid, 0);
        tick();
        slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
        slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
        #1;
        chk("at_r_valid", slv_resp.r_valid, 1);
        chk("at_r_id", slv_resp.r.id, 7);
        chk("at_r_last", slv_resp.r.last, 1);
        chk("at_w_ready", slv_resp.w_ready, 1);
        tick();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        slv_req.b_ready = 1'b1;
        #1;
        chk("at_b_valid", slv_resp.b_valid, 1);
        chk("at_b_id", slv_resp.b.id, 7);
        chk("at_r_gone", slv_resp.r_valid, 0);
        tick();
        idle_bus();
        tick();

        // isolated_i falls during WData with a new AW pending
        slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd4;
        #1;
        chk("lf_aw_ready", slv_resp.aw_ready, 1);
        tick();
        isolated_i = 1'b0;
        slv_req.aw.id = 4'd6;
        slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
        mst_resp.aw_ready = 1'b1;
        #1;
        chk("lf_wdata_no_aw", mst_req.aw_valid, 0);
        chk("lf_wdata_aw_ready", slv_resp.aw_ready, 0);
        chk("lf_w_ready", slv_resp.w_ready, 1);
        tick();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        #1;
        chk("lf_wresp_no_aw", mst_req.aw_valid, 0);
        chk("lf_b_valid", slv_resp.b_valid, 1);
        chk("lf_b_id", slv_resp.b.id, 4);
        tick();
        slv_req.b_ready = 1'b1;
        #1;
        chk("lf_bhs_no_aw", mst_req.aw_valid, 0);
        chk("lf_bhs_aw_ready", slv_resp.aw_ready, 0);
        tick();
        slv_req.b_ready = 1'b0;
        #1;
        chk("lf_aw_fwd", mst_req.aw_valid, 1);
        chk("lf_aw_fwd_id", mst_req.aw.id, 6);
        chk("lf_aw_fwd_ready", slv_resp.aw_ready, 1);
        chk("lf_b_cleared", slv_resp.b_valid, 0);
        tick();
        idle_bus();

        // Reset during an error read burst with counter at 2
        isolated_i = 1'b1;
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd3; slv_req.ar.len = 8'd4;
        tick();
        slv_req.ar_valid = 1'b0;
        slv_req.r_ready  = 1'b1;
        tick();
        tick();
        slv_req.r_ready = 1'b0;
        #1;
        chk("rs_r_valid_pre", slv_resp.r_valid, 1);
        chk("rs_r_last_pre", slv_resp.r.last, 0);
        rst_ni = 1'b0;
        #1;
        chk("rs_r_valid_rst", slv_resp.r_valid, 0);
        tick();
        rst_ni = 1'b1;
        isolated_i = 1'b0;
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd8; slv_req.ar.len = 8'd0;
        mst_resp.ar_ready = 1'b1;
        #1;
        chk("rs_pt_ar_valid", mst_req.ar_valid, 1);
        chk("rs_pt_ar_ready", slv_resp.ar_ready, 1);
        chk("rs_pt_r_valid", slv_resp.r_valid, 0);
        tick();
        idle_bus();
        isolated_i = 1'b1;
        slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd10; slv_req.ar.len = 8'd0;
        #1;
        chk("rs_err_mst_ar", mst_req.ar_valid, 0);
        chk("rs_err_ar_ready", slv_resp.ar_ready, 1);
        tick();
        slv_req.ar_valid = 1'b0;
        slv_req.r_ready  = 1'b1;
        #1;
        chk("rs_err_r_valid", slv_resp.r_valid, 1);
        chk("rs_err_r_id", slv_resp.r.id, 10);
        chk("rs_err_r_last", slv_resp.r.last, 1);
        tick();
        #1;
        chk("rs_err_r_done", slv_resp.r_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
